// File: rtl/tri_cfg_pkg.sv
// tri_cfg_pkg: shared encodings and default widths for the triangle DDS config sequencer.
package tri_cfg_pkg;
    typedef logic [1:0] cfg_sel_t;
    typedef logic [1:0] state_t;
    localparam cfg_sel_t SEL_FREQ   = 2'd0;
    localparam cfg_sel_t SEL_PCW    = 2'd1;
    localparam cfg_sel_t SEL_AMP    = 2'd2;
    localparam cfg_sel_t SEL_OFFSET = 2'd3;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ARMED = 2'd1;
    localparam state_t ST_RAMP  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;
    localparam int CFG_W      = 32;
    localparam int FREQ_W_DEF = 32;
    localparam int PCW_W_DEF  = 10;
    localparam int AMP_W_DEF  = 16;
endpackage

// File: rtl/triangle_cfg_sequencer_if.sv
// triangle_cfg_sequencer_if: host shadow-write and commit bus.
interface triangle_cfg_sequencer_if;
    import tri_cfg_pkg::*;
    logic             cfg_valid;
    logic             cfg_ready;
    cfg_sel_t         cfg_sel;
    logic [CFG_W-1:0] cfg_data;
    logic             commit_req;
    modport master(output cfg_valid, cfg_sel, cfg_data, commit_req, input cfg_ready);
    modport slave(input cfg_valid, cfg_sel, cfg_data, commit_req, output cfg_ready);
endinterface

// File: rtl/tri_amp_ramp.sv
// tri_amp_ramp: divided tick counter plus clamped amplitude stepper toward a target.
module tri_amp_ramp #(
    parameter int AMP_W    = 16,
    parameter int AMP_STEP = 125,
    parameter int RAMP_DIV = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [AMP_W-1:0] tgt_i,
    output logic [AMP_W-1:0] amp_o,
    output logic             done_o
);
    localparam int CNT_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    logic [AMP_W:0]   a, t, s, up, dn, nxt;
    logic             tick;
    always_comb begin
        a      = {1'b0, amp_q};
        t      = {1'b0, tgt_i};
        s      = (AMP_W+1)'(AMP_STEP);
        up     = (a + s > t) ? t : a + s;
        dn     = (a - t <= s) ? t : a - s;
        nxt    = (t > a) ? up : dn;
        tick   = en_i && (cnt_q == CNT_W'(RAMP_DIV - 1));
        cnt_d  = (!en_i || tick) ? '0 : cnt_q + CNT_W'(1);
        amp_d  = tick ? nxt[AMP_W-1:0] : amp_q;
        done_o = tick && (nxt == t);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            amp_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            amp_q <= amp_d;
        end
    end
    assign amp_o = amp_q;
endmodule

// File: rtl/triangle_cfg_sequencer.sv
// triangle_cfg_sequencer: shadowed DDS parameters applied on phase wrap, amplitude soft-ramped.
module triangle_cfg_sequencer
    import tri_cfg_pkg::*;
#(
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int PCW_W    = PCW_W_DEF,
    parameter int AMP_W    = AMP_W_DEF,
    parameter int RST_FREQ = 80000,
    parameter int RST_AMP  = 12500,
    parameter int AMP_STEP = 125,
    parameter int RAMP_DIV = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    triangle_cfg_sequencer_if.slave    cfg,
    input  logic                       wrap_pulse,
    output logic [FREQ_W-1:0]          dds_freq,
    output logic [PCW_W-1:0]           dds_pcw,
    output logic [AMP_W-1:0]           dds_amp,
    output logic [AMP_W-1:0]           dds_dc_offset,
    output logic                       busy,
    output logic                       commit_done
);
    state_t            state_q, state_d;
    logic [FREQ_W-1:0] sh_freq_q, sh_freq_d, freq_q, freq_d;
    logic [PCW_W-1:0]  sh_pcw_q, sh_pcw_d, pcw_q, pcw_d;
    logic [AMP_W-1:0]  sh_amp_q, sh_amp_d;
    logic [AMP_W-1:0]  sh_off_q, sh_off_d, off_q, off_d;
    logic              wr, load, ramp_done;
    tri_amp_ramp #(.AMP_W(AMP_W), .AMP_STEP(AMP_STEP), .RAMP_DIV(RAMP_DIV)) u_ramp (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_RAMP),
        .tgt_i  (sh_amp_q),
        .amp_o  (dds_amp),
        .done_o (ramp_done)
    );
    // Shadow writes only land in IDLE, so the ramp target is stable for the whole commit.
    always_comb begin
        wr        = cfg.cfg_valid && (state_q == ST_IDLE);
        load      = (state_q == ST_ARMED) && wrap_pulse;
        sh_freq_d = (wr && cfg.cfg_sel == SEL_FREQ)   ? cfg.cfg_data[FREQ_W-1:0] : sh_freq_q;
        sh_pcw_d  = (wr && cfg.cfg_sel == SEL_PCW)    ? cfg.cfg_data[PCW_W-1:0]  : sh_pcw_q;
        sh_amp_d  = (wr && cfg.cfg_sel == SEL_AMP)    ? cfg.cfg_data[AMP_W-1:0]  : sh_amp_q;
        sh_off_d  = (wr && cfg.cfg_sel == SEL_OFFSET) ? cfg.cfg_data[AMP_W-1:0]  : sh_off_q;
        freq_d    = load ? sh_freq_q : freq_q;
        pcw_d     = load ? sh_pcw_q  : pcw_q;
        off_d     = load ? sh_off_q  : off_q;
        state_d   = (state_q == ST_IDLE && cfg.commit_req) ? ST_ARMED :
                    load ? ((sh_amp_q != dds_amp) ? ST_RAMP : ST_DONE) :
                    (state_q == ST_RAMP && ramp_done) ? ST_DONE :
                    (state_q == ST_DONE) ? ST_IDLE : state_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sh_freq_q <= FREQ_W'(RST_FREQ);
            sh_pcw_q  <= '0;
            sh_amp_q  <= AMP_W'(RST_AMP);
            sh_off_q  <= '0;
            freq_q    <= FREQ_W'(RST_FREQ);
            pcw_q     <= '0;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            sh_freq_q <= sh_freq_d;
            sh_pcw_q  <= sh_pcw_d;
            sh_amp_q  <= sh_amp_d;
            sh_off_q  <= sh_off_d;
            freq_q    <= freq_d;
            pcw_q     <= pcw_d;
            off_q     <= off_d;
        end
    end
    assign cfg.cfg_ready  = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign commit_done    = (state_q == ST_DONE);
    assign dds_freq       = freq_q;
    assign dds_pcw        = pcw_q;
    assign dds_dc_offset  = off_q;
endmodule

// File: tb/tb_triangle_cfg_sequencer.sv
// tb_triangle_cfg_sequencer: directed vectors against default and a step-30 / div-2 instance.
module tb_triangle_cfg_sequencer;
    import tri_cfg_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrap_a = 1'b0, wrap_b = 1'b0;
    logic [31:0] freq_a, freq_b;
    logic [9:0]  pcw_a, pcw_b;
    logic [15:0] amp_a, amp_b, off_a, off_b;
    logic        busy_a, busy_b, cd_a, cd_b;
    int          n_cmp = 0, n_bad = 0;
    triangle_cfg_sequencer_if ia ();
    triangle_cfg_sequencer_if ib ();
    triangle_cfg_sequencer u_a (
        .clk(clk), .rst(rst), .cfg(ia), .wrap_pulse(wrap_a),
        .dds_freq(freq_a), .dds_pcw(pcw_a), .dds_amp(amp_a), .dds_dc_offset(off_a),
        .busy(busy_a), .commit_done(cd_a)
    );
    triangle_cfg_sequencer #(.AMP_STEP(30), .RAMP_DIV(2)) u_b (
        .clk(clk), .rst(rst), .cfg(ib), .wrap_pulse(wrap_b),
        .dds_freq(freq_b), .dds_pcw(pcw_b), .dds_amp(amp_b), .dds_dc_offset(off_b),
        .busy(busy_b), .commit_done(cd_b)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr_a(input cfg_sel_t sel, input logic [31:0] data);
        ia.cfg_valid = 1'b1;
        ia.cfg_sel   = sel;
        ia.cfg_data  = data;
        tick();
        ia.cfg_valid = 1'b0;
    endtask
    task automatic commit_a();
        ia.commit_req = 1'b1;
        tick();
        ia.commit_req = 1'b0;
    endtask
    task automatic wrap_a_once();
        wrap_a = 1'b1;
        tick();
        wrap_a = 1'b0;
    endtask
    int cd_seen;
    int exp_b[4] = '{12470, 12440, 12410, 12400};
    initial begin
        ia.cfg_valid = 0; ia.cfg_sel = SEL_FREQ; ia.cfg_data = 0; ia.commit_req = 0;
        ib.cfg_valid = 0; ib.cfg_sel = SEL_FREQ; ib.cfg_data = 0; ib.commit_req = 0;
        // 1: reset values
        tick();
        check("rst_freq", freq_a, 80000);
        check("rst_amp", amp_a, 0);
        check("rst_pcw", pcw_a, 0);
        check("rst_off", off_a, 0);
        check("rst_ready", ia.cfg_ready, 1);
        check("rst_busy", busy_a, 0);
        check("rst_cd", cd_a, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy_a, 0);
        // 2: freq/pcw/offset applied on wrap; wrap coinciding with commit is not counted
        wr_a(SEL_AMP, 0);
        wr_a(SEL_FREQ, 160000);
        wr_a(SEL_PCW, 32'hFFFF_F3FF);
        wr_a(SEL_OFFSET, 1000);
        ia.commit_req = 1'b1; wrap_a = 1'b1;
        tick();
        ia.commit_req = 1'b0; wrap_a = 1'b0;
        check("armed_busy", busy_a, 1);
        check("armed_ready", ia.cfg_ready, 0);
        check("armed_cd", cd_a, 0);
        for (int i = 0; i < 9; i++) tick();
        check("prewrap_freq", freq_a, 80000);
        check("prewrap_pcw", pcw_a, 0);
        wrap_a_once();
        check("wrap_freq", freq_a, 160000);
        check("wrap_pcw", pcw_a, 1023);
        check("wrap_off", off_a, 1000);
        check("wrap_amp", amp_a, 0);
        check("wrap_cd", cd_a, 1);
        tick();
        check("post_cd", cd_a, 0);
        check("post_busy", busy_a, 0);
        // 3: write and commit in the same cycle, then ramp 0 -> 12500
        ia.cfg_valid = 1'b1; ia.cfg_sel = SEL_AMP; ia.cfg_data = 12500; ia.commit_req = 1'b1;
        tick();
        ia.cfg_valid = 1'b0; ia.commit_req = 1'b0;
        wrap_a_once();
        check("ramp_start_amp", amp_a, 0);
        check("ramp_busy", busy_a, 1);
        cd_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            for (int i = 0; i < 49; i++) begin
                // 5: host traffic during RAMP must stall and be ignored
                if (k == 10 && i == 0) begin
                    ia.cfg_valid = 1'b1; ia.cfg_sel = SEL_FREQ; ia.cfg_data = 999;
                    ia.commit_req = 1'b1; wrap_a = 1'b1;
                    check("ramp_ready", ia.cfg_ready, 0);
                end
                tick();
                ia.cfg_valid = 1'b0; ia.commit_req = 1'b0; wrap_a = 1'b0;
                cd_seen += int'(cd_a);
            end
            check("amp_hold", amp_a, 125 * (k - 1));
            tick();
            check("amp_step", amp_a, 125 * k);
            if (k < 100) cd_seen += int'(cd_a);
        end
        check("ramp_no_early_cd", cd_seen, 0);
        check("ramp_end_cd", cd_a, 1);
        check("ramp_freq", freq_a, 160000);
        check("ramp_pcw", pcw_a, 1023);
        check("ramp_off", off_a, 1000);
        tick();
        check("ramp_post_cd", cd_a, 0);
        check("ramp_post_busy", busy_a, 0);
        commit_a();
        wrap_a_once();
        check("stalled_write_freq", freq_a, 160000);
        check("equal_amp_cd", cd_a, 1);
        tick();
        check("equal_amp_busy", busy_a, 0);
        // 6: async reset mid-ramp
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("rerst_amp", amp_a, 0);
        wr_a(SEL_FREQ, 12345);
        commit_a();
        wrap_a_once();
        check("rerst_wrap_freq", freq_a, 12345);
        for (int i = 0; i < 2400; i++) tick();
        check("mid_amp", amp_a, 6000);
        #2 rst = 1'b1;
        #1;
        check("async_freq", freq_a, 80000);
        check("async_amp", amp_a, 0);
        check("async_busy", busy_a, 0);
        check("async_ready", ia.cfg_ready, 1);
        #2 rst = 1'b0;
        tick();
        cd_seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cd_seen += int'(cd_a);
        end
        check("async_no_cd", cd_seen, 0);
        check("async_amp_stay", amp_a, 0);
        check("async_busy_stay", busy_a, 0);
        // 4: step 30, ramp 12500 -> 12400 with clamped final step
        ib.commit_req = 1'b1; tick(); ib.commit_req = 1'b0;
        wrap_b = 1'b1; tick(); wrap_b = 1'b0;
        for (int i = 0; i < 2000 && !cd_b; i++) tick();
        check("b_up_cd", cd_b, 1);
        check("b_up_amp", amp_b, 12500);
        tick();
        ib.cfg_valid = 1'b1; ib.cfg_sel = SEL_AMP; ib.cfg_data = 12400;
        tick();
        ib.cfg_valid = 1'b0;
        ib.commit_req = 1'b1; tick(); ib.commit_req = 1'b0;
        wrap_b = 1'b1; tick(); wrap_b = 1'b0;
        check("b_dn_start", amp_b, 12500);
        for (int j = 0; j < 4; j++) begin
            tick(); tick();
            check("b_dn_step", amp_b, exp_b[j]);
        end
        check("b_dn_cd", cd_b, 1);
        tick();
        check("b_dn_busy", busy_b, 0);
        check("b_dn_final", amp_b, 12400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
